// File: rtl/lib_intr.sv
// Shared types and helpers for the interrupt controller.
package lib_intr;

  localparam int INTR_MAX_SRC = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } INTR_STATE;

  // Fixed-priority select: bit 5 = any bit set, bits [4:0] = lowest set index.
  function automatic logic [5:0] prio_lowest(input logic [INTR_MAX_SRC-1:0] vec);
    logic [4:0] idx;
    idx = '0;
    // Walk from the top down so the lowest set index is the one left standing.
    for (int i = INTR_MAX_SRC - 1; i >= 0; i--) begin
      if (vec[i]) idx = 5'(i);
    end
    return {|vec, idx};
  endfunction

endpackage

// File: rtl/intr_edge.sv
// Per-bit rising-edge detector for the peripheral interrupt levels.
module intr_edge #(
  parameter int N_SRC = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src,
  output logic [N_SRC-1:0] rise
);

  logic [N_SRC-1:0] src_d;

  // One-cycle delayed copy; clears to 0 so a level already high at reset
  // release shows up as one rise in the first cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) src_d <= '0;
    else       src_d <= src;
  end

  assign rise = src & ~src_d;

endmodule

// File: rtl/intr_ctrl.sv
// Multi-source interrupt controller: edge-detects sources into pending bits,
// picks the lowest-index unmasked pending source and runs the
// request / icall / ack / iret sequence with the CPU execute stage.
//
// Handshake with the core: irq is held high in REQ until the core takes the
// interrupt, which it signals by dropping intr_en (1 -> 0). In SERVICE the
// core either pulses ack (pending bit of the served source cleared) or raises
// intr_en again without ack (iret; pending kept, source re-requested). ack
// wins when both happen in one cycle; ack outside SERVICE has no effect.
module intr_ctrl
  import lib_intr::*;
#(
  parameter int N_SRC = 4,
  parameter int ID_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src,
  input  logic             intr_en,
  input  logic             ack,
  input  logic             mask_we,
  input  logic [31:0]      mask_wdata,
  output logic             irq,
  output logic [31:0]      cause,
  output logic [31:0]      pending,
  output INTR_STATE        state
);

  logic [N_SRC-1:0]        rise;
  logic [N_SRC-1:0]        pending_q;
  logic [N_SRC-1:0]        mask_q;
  logic [N_SRC-1:0]        clr;
  logic [ID_W-1:0]         id_q;
  logic                    intr_en_d;
  logic [INTR_MAX_SRC-1:0] elig;
  logic [5:0]              sel;
  logic                    en_fall;
  logic                    en_rise;
  INTR_STATE               state_q;
  logic                    mask_wdata_unused;

  intr_edge #(.N_SRC(N_SRC)) u_edge (
    .clk   (clk),
    .reset (reset),
    .src   (src),
    .rise  (rise)
  );

  assign elig    = INTR_MAX_SRC'(pending_q & mask_q);
  assign sel     = prio_lowest(elig);
  assign en_fall = intr_en_d & ~intr_en;
  assign en_rise = intr_en & ~intr_en_d;

  // Bits of the mask write above N_SRC have no register behind them.
  assign mask_wdata_unused = ^mask_wdata;

  // Clear strobe for the served source: only an ack while in SERVICE counts.
  always_comb begin
    clr = '0;
    if (state_q == SERVICE && ack) clr[id_q] = 1'b1;
  end

  // Pending and mask registers; a new rise beats a same-cycle clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q <= '0;
      mask_q    <= '0;
      intr_en_d <= 1'b0;
    end else begin
      pending_q <= (pending_q & ~clr) | rise;
      if (mask_we) mask_q <= mask_wdata[N_SRC-1:0];
      intr_en_d <= intr_en;
    end
  end

  // Request FSM with registered irq; id is captured on REQ entry and frozen
  // until the sequence returns to IDLE (no pre-emption, no nesting).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      id_q    <= '0;
      irq     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          irq <= 1'b0;
          if (intr_en && sel[5]) begin
            id_q    <= ID_W'(sel[4:0]);
            state_q <= REQ;
            irq     <= 1'b1;
          end
        end
        REQ: begin
          if (en_fall) begin
            state_q <= SERVICE;
            irq     <= 1'b0;
          end else if (!mask_q[id_q]) begin
            state_q <= IDLE;
            irq     <= 1'b0;
          end else begin
            irq <= 1'b1;
          end
        end
        SERVICE: begin
          irq <= 1'b0;
          if (ack || en_rise) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          irq     <= 1'b0;
        end
      endcase
    end
  end

  assign cause   = 32'(id_q);
  assign pending = 32'(pending_q);
  assign state   = state_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Bench for intr_ctrl: directed sequences plus a randomised CPU/peripheral
// phase, checked cycle by cycle against a behavioural model via a scoreboard.
module tb_intr_ctrl;

  localparam int N = 4;
  localparam int W = 66; // {cause_valid, irq, cause[31:0], pending[31:0]}

  logic               clk;
  logic               reset;
  logic [N-1:0]       src;
  logic               intr_en;
  logic               ack;
  logic               mask_we;
  logic [31:0]        mask_wdata;
  logic               irq;
  logic [31:0]        cause;
  logic [31:0]        pending;
  lib_intr::INTR_STATE state;

  intr_ctrl #(.N_SRC(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .src        (src),
    .intr_en    (intr_en),
    .ack        (ack),
    .mask_we    (mask_we),
    .mask_wdata (mask_wdata),
    .irq        (irq),
    .cause      (cause),
    .pending    (pending),
    .state      (state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  logic mon_en = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: after every active edge, compare outputs with the oldest expectation.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("irq", 32'(irq), 32'(e[64]));
        check("pending", pending, e[31:0]);
        if (e[65]) check("cause", cause, e[63:32]);
      end
    end
  end

  // ---------------- reference model ----------------
  // phase: 0 = no request, 1 = requesting the core, 2 = core servicing
  int           m_phase;
  int           m_id;
  logic [N-1:0] m_pend, m_mask, m_src_prev;
  logic         m_en_prev;

  function automatic int lowest(input logic [N-1:0] v);
    logic [31:0] x;
    x = 32'(v);
    x = x & (~x + 32'd1);
    return $clog2(x);
  endfunction

  task automatic model_reset();
    m_phase = 0; m_id = 0;
    m_pend = '0; m_mask = '0; m_src_prev = '0; m_en_prev = 1'b0;
  endtask

  // ---------------- driver ----------------
  logic [N-1:0] n_src;
  logic         n_en, n_ack, n_we;
  logic [31:0]  n_wd;

  // Apply the next-cycle inputs (called at a negedge), advance the model over
  // the coming posedge, push the expectation, then wait for the next negedge.
  task automatic step();
    logic [N-1:0] rises, clr;
    src = n_src; intr_en = n_en; ack = n_ack; mask_we = n_we; mask_wdata = n_wd;
    rises = n_src & ~m_src_prev;
    clr = '0;
    case (m_phase)
      0: if (n_en && (m_pend & m_mask) != 0) begin
           m_id = lowest(m_pend & m_mask);
           m_phase = 1;
         end
      1: if (m_en_prev && !n_en) m_phase = 2;
         else if (!m_mask[m_id]) m_phase = 0;
      default: if (n_ack) begin
                 clr[m_id] = 1'b1;
                 m_phase = 0;
               end else if (n_en && !m_en_prev) m_phase = 0;
    endcase
    m_pend = (m_pend & ~clr) | rises;
    if (n_we) m_mask = n_wd[N-1:0];
    m_src_prev = n_src;
    m_en_prev = n_en;
    exp_q.push_back({m_phase != 0, m_phase == 1, 32'(m_id), 32'(m_pend)});
    n_ack = 1'b0;
    n_we = 1'b0;
    @(negedge clk);
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic write_mask(input logic [31:0] v);
    n_we = 1'b1; n_wd = v;
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r;
    reset = 1'b1; src = '0; intr_en = 1'b0; ack = 1'b0; mask_we = 1'b0; mask_wdata = '0;
    n_src = '0; n_en = 1'b0; n_ack = 1'b0; n_we = 1'b0; n_wd = '0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("reset_irq", 32'(irq), 32'd0);
    check("reset_cause", cause, 32'd0);
    check("reset_pending", pending, 32'd0);
    check("reset_state", 32'(state), 32'(lib_intr::IDLE));
    mon_en = 1'b1;

    // 1: single source request
    write_mask(32'h1);
    n_en = 1'b1; cyc(3);
    n_src = 4'b0001; cyc(1);
    n_src = 4'b0000; cyc(4);
    // 2: icall, ack, iret with nothing left pending
    n_en = 1'b0; cyc(3);
    n_ack = 1'b1; cyc(1);
    cyc(2);
    n_en = 1'b1; cyc(4);
    // 3: simultaneous rises, lowest index first, then the other
    write_mask(32'hF);
    n_src = 4'b1010; cyc(1);
    n_src = 4'b0000; cyc(3);
    n_en = 1'b0; cyc(2);
    n_ack = 1'b1; cyc(1);
    n_en = 1'b1; cyc(4);
    n_en = 1'b0; cyc(2);
    n_ack = 1'b1; cyc(2);
    // 4: withdraw a request by masking, then restore
    n_src = 4'b0100; cyc(1);
    n_src = 4'b0000; cyc(1);
    n_en = 1'b1; cyc(3);
    write_mask(32'hFFFF_FFFB); cyc(3);
    write_mask(32'hF); cyc(3);
    n_en = 1'b0; cyc(2);
    n_ack = 1'b1; cyc(2);
    // 5: new rise coinciding with ack keeps the pending bit
    n_en = 1'b1;
    n_src = 4'b0001; cyc(1);
    n_src = 4'b0000; cyc(3);
    n_en = 1'b0; cyc(2);
    n_src = 4'b0001; n_ack = 1'b1; cyc(1);
    n_src = 4'b0000; cyc(2);
    n_en = 1'b1; cyc(4);
    // 6: asynchronous reset while in SERVICE
    n_en = 1'b0; cyc(2);
    @(posedge clk); #3;
    mon_en = 1'b0;
    reset = 1'b1;
    #1;
    check("async_irq", 32'(irq), 32'd0);
    check("async_cause", cause, 32'd0);
    check("async_pending", pending, 32'd0);
    check("async_state", 32'(state), 32'(lib_intr::IDLE));
    src = 4'b0001;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    mon_en = 1'b1;
    n_src = 4'b0001; n_en = 1'b1; cyc(4);
    write_mask(32'h1); cyc(3);
    n_en = 1'b0; cyc(2);
    n_ack = 1'b1; n_src = 4'b0000; cyc(2);

    // randomised phase: core behaviour driven from the model's phase
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) n_src = 4'($urandom_range(0, 15));
      case (m_phase)
        0: if (!n_en && $urandom_range(0, 2) == 0) n_en = 1'b1;
           else if (n_en && $urandom_range(0, 15) == 0) n_en = 1'b0;
        1: if ($urandom_range(0, 3) == 0) n_en = 1'b0;
        default: begin
          r = $urandom_range(0, 7);
          if (r < 2) n_ack = 1'b1;
          else if (r == 2) n_en = 1'b1;
          else if (r == 3) begin n_ack = 1'b1; n_en = 1'b1; end
        end
      endcase
      if (m_phase != 2 && $urandom_range(0, 15) == 0) n_ack = 1'b1;
      if ($urandom_range(0, 19) == 0) begin n_we = 1'b1; n_wd = $urandom(); end
      step();
    end
    cyc(4);
    @(posedge clk); #3;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
